// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: issues one data-memory request per
// aligned access, stalls the pipeline until ack or timeout, then returns the
// lane-extracted, sign/zero-extended load result.
module mem_access_unit #(
  parameter int NB_REG     = 32,
  parameter int NB_TIMEOUT = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [NB_REG-1:0] i_alu_result,
  input  logic [NB_REG-1:0] i_write_data,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_width,
  input  logic              i_unsigned,
  output logic              o_mem_req,
  output logic [NB_REG-1:0] o_mem_addr,
  output logic [NB_REG-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_be,
  output logic              o_mem_we,
  input  logic              i_mem_ack,
  input  logic [NB_REG-1:0] i_mem_rdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [NB_REG-1:0] o_load_data,
  output logic              o_misaligned,
  output logic              o_bus_error
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // Last counter value before the limit: a miss here means the limit is hit.
  localparam logic [NB_TIMEOUT-1:0] CNT_LAST = {{(NB_TIMEOUT-1){1'b1}}, 1'b0};

  state_t                state_q, state_d;
  logic [NB_REG-1:0]     addr_q, wdata_q, load_q;
  logic [3:0]            be_q;
  logic [1:0]            width_q, off_q;
  logic                  uns_q, we_q, berr_q, mis_q;
  logic [NB_TIMEOUT-1:0] cnt_q;

  logic              access, aligned, start, mis_d, timeout;
  logic [3:0]        be_d;
  logic [NB_REG-1:0] wdata_d, ext;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign access  = i_valid & (i_mem_read | i_mem_write);
  assign start   = (state_q == IDLE) & access & aligned;
  assign mis_d   = (state_q == IDLE) & access & ~aligned;
  assign timeout = (state_q == BUSY) & ~i_mem_ack & (cnt_q == CNT_LAST);

  // Alignment check, lane enables and replicated store data for the request.
  always_comb begin
    aligned = 1'b0;
    be_d    = 4'b1111;
    wdata_d = i_write_data;
    case (i_width)
      2'b00: begin
        aligned = 1'b1;
        be_d    = 4'b0001 << i_alu_result[1:0];
        wdata_d = NB_REG'({4{i_write_data[7:0]}});
      end
      2'b01: begin
        aligned = ~i_alu_result[0];
        be_d    = 4'b0011 << i_alu_result[1:0];
        wdata_d = NB_REG'({2{i_write_data[15:0]}});
      end
      2'b10:   aligned = (i_alu_result[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    byte_v = i_mem_rdata[{off_q, 3'b000} +: 8];
    half_v = i_mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (width_q)
      2'b00:   ext = {{(NB_REG-8){byte_v[7] & ~uns_q}}, byte_v};
      2'b01:   ext = {{(NB_REG-16){half_v[15] & ~uns_q}}, half_v};
      default: ext = i_mem_rdata;
    endcase
  end

  // Next-state logic: DONE is reached by ack or by timeout, and lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (i_mem_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Request capture, timeout counter, load result and one-cycle error pulses.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      be_q    <= '0;
      width_q <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      berr_q  <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mis_q  <= mis_d;
      berr_q <= 1'b0;
      if (start) begin
        addr_q  <= {i_alu_result[NB_REG-1:2], 2'b00};
        off_q   <= i_alu_result[1:0];
        wdata_q <= wdata_d;
        be_q    <= be_d;
        width_q <= i_width;
        uns_q   <= i_unsigned;
        we_q    <= i_mem_write;   // write wins when both are requested
        cnt_q   <= '0;
      end
      if (state_q == BUSY) begin
        if (i_mem_ack) begin
          if (!we_q) load_q <= ext;
        end else if (timeout) begin
          load_q <= '0;
          berr_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign o_mem_req    = (state_q == BUSY);
  assign o_done       = (state_q == DONE);
  assign o_stall      = start | (state_q == BUSY);
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_be     = be_q;
  assign o_mem_we     = we_q;
  assign o_load_data  = load_q;
  assign o_misaligned = mis_q;
  assign o_bus_error  = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (NB_TIMEOUT=4 so timeouts are short).
module tb_mem_access_unit;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_mem_read, i_mem_write, i_unsigned, i_mem_ack;
  logic [NB-1:0] i_alu_result, i_write_data, i_mem_rdata;
  logic [1:0]    i_width;
  logic          o_mem_req, o_mem_we, o_stall, o_done, o_misaligned, o_bus_error;
  logic [NB-1:0] o_mem_addr, o_mem_wdata, o_load_data;
  logic [3:0]    o_mem_be;

  int checks = 0;
  int errors = 0;

  // per-access results
  int          r_stalls, r_busy, r_done, r_done_at;
  logic        r_berr, r_we;
  logic [31:0] r_load, r_addr, r_wdata;
  logic [3:0]  r_be;

  mem_access_unit #(.NB_REG(NB), .NB_TIMEOUT(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .i_alu_result(i_alu_result),
    .i_write_data(i_write_data), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_width(i_width), .i_unsigned(i_unsigned), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .o_mem_we(o_mem_we), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_stall(o_stall), .o_done(o_done), .o_load_data(o_load_data),
    .o_misaligned(o_misaligned), .o_bus_error(o_bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: start cycle, then BUSY windows numbered c=1.. with ack in
  // window ack_at (0 = never); also counts any o_done in the cycle after DONE.
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd,
                           input logic rd, input logic wr, input logic [1:0] w,
                           input logic u, input int ack_at, input logic [31:0] rdat);
    r_stalls = 0; r_busy = 0; r_done = 0; r_done_at = 0; r_berr = 1'b0;
    r_load = '0; r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
    tick();
    i_valid = 1'b1; i_alu_result = a; i_write_data = wd; i_mem_read = rd;
    i_mem_write = wr; i_width = w; i_unsigned = u; i_mem_ack = 1'b0;
    #1;
    if (o_stall) r_stalls++;
    for (int c = 1; c <= 40; c++) begin
      tick();
      i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
      i_mem_ack = (c == ack_at); i_mem_rdata = rdat;
      #1;
      if (c == 1) begin
        r_addr = o_mem_addr; r_be = o_mem_be; r_we = o_mem_we; r_wdata = o_mem_wdata;
      end
      if (o_mem_req) r_busy++;
      if (o_stall) r_stalls++;
      if (o_done) begin
        r_done++; r_done_at = c; r_berr = o_bus_error; r_load = o_load_data;
        break;
      end
    end
    tick();
    i_mem_ack = 1'b0;
    #1;
    if (o_done) r_done++;
  endtask

  initial begin
    rst = 1'b1; i_valid = 0; i_mem_read = 0; i_mem_write = 0; i_unsigned = 0;
    i_mem_ack = 0; i_alu_result = '0; i_write_data = '0; i_mem_rdata = '0; i_width = 2'b10;

    // reset state
    tick(); tick();
    chk("rst_req", {31'b0, o_mem_req}, 0);
    chk("rst_we", {31'b0, o_mem_we}, 0);
    chk("rst_be", {28'b0, o_mem_be}, 0);
    chk("rst_done", {31'b0, o_done}, 0);
    chk("rst_mis", {31'b0, o_misaligned}, 0);
    chk("rst_berr", {31'b0, o_bus_error}, 0);
    chk("rst_stall", {31'b0, o_stall}, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_load", o_load_data, 0);
    rst = 1'b0;

    // LW 0x104, ack in third BUSY cycle
    do_access(32'h104, 0, 1, 0, 2'b10, 0, 3, 32'hDEADBEEF);
    chk("lw_addr", r_addr, 32'h104);
    chk("lw_be", {28'b0, r_be}, 32'hF);
    chk("lw_we", {31'b0, r_we}, 0);
    chk("lw_stalls", r_stalls, 4);
    chk("lw_busy", r_busy, 3);
    chk("lw_done", r_done, 1);
    chk("lw_berr", {31'b0, r_berr}, 0);
    chk("lw_load", r_load, 32'hDEADBEEF);
    chk("lw_hold", o_load_data, 32'hDEADBEEF);

    // LB 0x103 signed, ack in first BUSY cycle
    do_access(32'h103, 0, 1, 0, 2'b00, 0, 1, 32'h80123456);
    chk("lb_addr", r_addr, 32'h100);
    chk("lb_be", {28'b0, r_be}, 32'h8);
    chk("lb_done_at", r_done_at, 2);
    chk("lb_stalls", r_stalls, 2);
    chk("lb_load", r_load, 32'hFFFFFF80);

    // LBU 0x103
    do_access(32'h103, 0, 1, 0, 2'b00, 1, 1, 32'h80123456);
    chk("lbu_load", r_load, 32'h00000080);

    // SH 0x0A2: store leaves load result alone
    do_access(32'h0A2, 32'h1234ABCD, 0, 1, 2'b01, 0, 1, 32'hFFFFFFFF);
    chk("sh_we", {31'b0, r_we}, 1);
    chk("sh_be", {28'b0, r_be}, 32'hC);
    chk("sh_wdata", r_wdata, 32'hABCDABCD);
    chk("sh_addr", r_addr, 32'h0A0);
    chk("sh_done", r_done, 1);
    chk("sh_load", r_load, 32'h00000080);

    // LH 0x102 signed from upper half
    do_access(32'h102, 0, 1, 0, 2'b01, 0, 2, 32'h80011234);
    chk("lh_be", {28'b0, r_be}, 32'hC);
    chk("lh_load", r_load, 32'hFFFF8001);

    // LHU 0x100 from lower half
    do_access(32'h100, 0, 1, 0, 2'b01, 1, 1, 32'h0000F00D);
    chk("lhu_be", {28'b0, r_be}, 32'h3);
    chk("lhu_load", r_load, 32'h0000F00D);

    // SB 0x101
    do_access(32'h101, 32'h00000055, 0, 1, 2'b00, 0, 1, 0);
    chk("sb_be", {28'b0, r_be}, 32'h2);
    chk("sb_wdata", r_wdata, 32'h55555555);
    chk("sb_addr", r_addr, 32'h100);

    // read and write together: write wins, load result untouched
    do_access(32'h10, 32'hCAFEF00D, 1, 1, 2'b10, 0, 1, 32'h11111111);
    chk("rw_we", {31'b0, r_we}, 1);
    chk("rw_wdata", r_wdata, 32'hCAFEF00D);
    chk("rw_load", r_load, 32'h0000F00D);

    // misaligned LW 0x102
    tick();
    i_valid = 1; i_mem_read = 1; i_width = 2'b10; i_alu_result = 32'h102;
    #1;
    chk("mis_stall", {31'b0, o_stall}, 0);
    tick();
    i_valid = 0; i_mem_read = 0;
    #1;
    chk("mis_pulse", {31'b0, o_misaligned}, 1);
    chk("mis_req", {31'b0, o_mem_req}, 0);
    tick();
    chk("mis_clear", {31'b0, o_misaligned}, 0);

    // reserved width is never aligned
    i_valid = 1; i_mem_write = 1; i_width = 2'b11; i_alu_result = 32'h0;
    #1;
    chk("w11_stall", {31'b0, o_stall}, 0);
    tick();
    i_valid = 0; i_mem_write = 0;
    #1;
    chk("w11_mis", {31'b0, o_misaligned}, 1);
    chk("w11_req", {31'b0, o_mem_req}, 0);

    // valid with no access, and a stray ack in IDLE
    tick();
    i_valid = 1; i_width = 2'b10; i_mem_ack = 1;
    #1;
    chk("nop_stall", {31'b0, o_stall}, 0);
    tick();
    i_valid = 0; i_mem_ack = 0;
    #1;
    chk("nop_req", {31'b0, o_mem_req}, 0);
    chk("nop_done", {31'b0, o_done}, 0);
    chk("nop_mis", {31'b0, o_misaligned}, 0);

    // timeout: no ack at all
    do_access(32'h200, 0, 1, 0, 2'b10, 0, 0, 32'h12345678);
    chk("to_busy", r_busy, 15);
    chk("to_stalls", r_stalls, 16);
    chk("to_done", r_done, 1);
    chk("to_berr", {31'b0, r_berr}, 1);
    chk("to_load", r_load, 0);
    chk("to_berr_clear", {31'b0, o_bus_error}, 0);

    // ack in the same cycle the limit is reached
    do_access(32'h204, 0, 1, 0, 2'b10, 0, 15, 32'h0BADF00D);
    chk("lim_busy", r_busy, 15);
    chk("lim_berr", {31'b0, r_berr}, 0);
    chk("lim_load", r_load, 32'h0BADF00D);

    // reset in second BUSY cycle
    tick();
    i_valid = 1; i_mem_read = 1; i_width = 2'b10; i_alu_result = 32'h300;
    #1;
    chk("rb_start_stall", {31'b0, o_stall}, 1);
    tick();
    i_valid = 0; i_mem_read = 0;
    #1;
    chk("rb_b1_req", {31'b0, o_mem_req}, 1);
    tick();
    chk("rb_b2_req", {31'b0, o_mem_req}, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rb_req", {31'b0, o_mem_req}, 0);
    chk("rb_stall", {31'b0, o_stall}, 0);
    chk("rb_done", {31'b0, o_done}, 0);
    chk("rb_berr", {31'b0, o_bus_error}, 0);
    chk("rb_load", o_load_data, 0);
    tick();
    chk("rb_done2", {31'b0, o_done}, 0);

    // following SW completes normally
    do_access(32'h40, 32'h0F0F0F0F, 0, 1, 2'b10, 0, 2, 0);
    chk("sw_done", r_done, 1);
    chk("sw_busy", r_busy, 2);
    chk("sw_we", {31'b0, r_we}, 1);
    chk("sw_be", {28'b0, r_be}, 32'hF);
    chk("sw_wdata", r_wdata, 32'h0F0F0F0F);
    chk("sw_berr", {31'b0, r_berr}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter NB_REG, default 32: datapath and address width.
REQ-002 SHALL have parameter NB_TIMEOUT, default 8: width of the acknowledge-timeout counter; timeout limit is 2^NB_TIMEOUT-1 cycles.
REQ-003 SHALL use one clock and a synchronous, active-high reset: i_clock input 1 (rising edge), then i_reset input 1.
REQ-004 i_valid  input  1  EX/MEM stage holds a valid instruction.
REQ-005 i_alu_result  input  NB_REG  byte address produced by the EX-stage ALU.
REQ-006 i_write_data  input  NB_REG  store operand (rt).
REQ-007 i_mem_read / i_mem_write  input  1 each  load / store request.
REQ-008 i_width  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 i_unsigned  input  1  zero-extend loads (LBU/LHU) when 1, sign-extend when 0.
REQ-010 o_mem_req  output  1; o_mem_addr  output  NB_REG (word-aligned, bits[1:0]=0); o_mem_wdata  output  NB_REG; o_mem_be  output  4; o_mem_we  output  1.
REQ-011 i_mem_ack  input  1; i_mem_rdata  input  NB_REG  data memory response.
REQ-012 o_stall  output  1  freeze upstream pipeline.
REQ-013 o_done  output  1  one-cycle completion pulse; o_load_data  output  NB_REG  extended load result.
REQ-014 o_misaligned  output  1; o_bus_error  output  1  one-cycle error pulses.

Function
REQ-015 SHALL implement states IDLE, BUSY, DONE.
REQ-016 Start condition: IDLE & i_valid & (i_mem_read | i_mem_write) & aligned; aligned means byte: any address; half: addr[0]=0; word: addr[1:0]=00; width 11 is never aligned.
REQ-017 On start, SHALL register the address, data, byte enables, width, unsigned and we, and enter BUSY on the next edge; o_mem_req SHALL be 1 in every BUSY cycle and 0 otherwise.
REQ-018 o_stall SHALL be combinational: 1 when start is true in IDLE, and in all BUSY cycles; 0 in DONE and otherwise.
REQ-019 When i_mem_read and i_mem_write are both 1, write SHALL take priority (o_mem_we=1, no load result updated).
REQ-020 Byte enables, little-endian: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; for loads o_mem_be SHALL still reflect the accessed lanes.
REQ-021 o_mem_wdata SHALL replicate the store lane: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
REQ-022 In BUSY, i_mem_ack=1 SHALL capture i_mem_rdata and move to DONE on that edge; o_mem_req drops in DONE.
REQ-023 Load extraction: byte = rdata[8*addr[1:0]+:8], half = rdata[8*addr[1:0]+:16], word = rdata; sign- or zero-extended per i_unsigned to NB_REG.
REQ-024 o_done SHALL be 1 for exactly the one DONE cycle; DONE always returns to IDLE next edge; o_load_data SHALL hold its value until the next completed load.
REQ-025 Timeout: counter clears on BUSY entry, increments each BUSY cycle without ack; reaching 2^NB_TIMEOUT-1 SHALL force DONE with o_load_data=0 and o_bus_error=1 in that DONE cycle (o_done also 1).
REQ-026 Ack in the same cycle the counter reaches the limit SHALL be treated as a normal completion (no bus error).
REQ-027 Misaligned start (valid access, not aligned) in IDLE SHALL issue no request, no stall, and pulse o_misaligned for one cycle on the following cycle.
REQ-028 i_mem_ack outside BUSY SHALL be ignored; i_valid with neither read nor write SHALL do nothing.
REQ-029 Latency with ack in first BUSY cycle: start cycle N, o_mem_req cycle N+1, o_done cycle N+2.

Reset
REQ-030 i_reset=1 at a rising edge SHALL force IDLE, counter 0, and o_mem_req, o_mem_we, o_mem_be, o_done, o_misaligned, o_bus_error, o_stall (registered part) to 0, o_mem_addr, o_mem_wdata, o_load_data to 0.
REQ-031 Reset during BUSY SHALL abandon the access with no o_done and no error pulse; o_mem_req is 0 in the cycle after the reset edge.

Verification
REQ-032 LW addr 0x0000_0104, ack after 3 BUSY cycles, rdata 0xDEAD_BEEF -> o_mem_addr 0x104, be 1111, stall 4 cycles, o_done once, o_load_data 0xDEADBEEF.
REQ-033 LB addr 0x103, rdata 0x80xx_xxxx, i_unsigned=0 -> be 1000, o_load_data 0xFFFF_FF80; same with i_unsigned=1 -> 0x0000_0080.
REQ-034 SH addr 0x0A2, wd 0x1234_ABCD -> o_mem_we 1, be 1100, o_mem_wdata 0xABCD_ABCD, o_mem_addr 0x0A0.
REQ-035 LW addr 0x102 -> no o_mem_req, o_stall 0, o_misaligned pulse next cycle.
REQ-036 LW with no ack, NB_TIMEOUT=4 -> 15 BUSY cycles, then o_bus_error and o_done together, o_load_data 0; separately ack on cycle 15 -> normal completion.
REQ-037 Reset asserted in second BUSY cycle -> IDLE, o_mem_req 0 next cycle, no o_done; following SW completes normally.
